// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scanner with per-slot blanking guard, PWM brightness
// and once-per-frame shadow latching. Optional: `define SEG_LZ_SUPPRESS_EN for leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned GUARD_CYCLES = 64,
    parameter int unsigned GW           = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        segclk,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [2:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    state_e        state_q;
    logic [1:0]    digit_q;
    logic [GW-1:0] guard_q;
    logic [2:0]    pwm_q;
    logic          segclk_q;
    logic [15:0]   sh_value_q;
    logic [3:0]    sh_dp_q;
    logic [2:0]    sh_bright_q;
    logic [3:0]    an_q,   an_d;
    logic [6:0]    seg_q,  seg_d;
    logic          dp_n_q, dp_n_d;

    logic          tick;
    logic          guard_done;
    logic [3:0]    nibble;
    logic          suppress;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick       = segclk & ~segclk_q;
    assign guard_done = (guard_q == GW'(GUARD_CYCLES - 1));
    assign nibble     = sh_value_q[{digit_q, 2'b00} +: 4];

`ifdef SEG_LZ_SUPPRESS_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        suppress = 1'b0;
        case (digit_q)
            2'd3:    suppress = (sh_value_q[15:12] == 4'h0);
            2'd2:    suppress = (sh_value_q[15:8]  == 8'h00);
            2'd1:    suppress = (sh_value_q[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        an_d   = 4'b1111;
        seg_d  = 7'b1111111;
        dp_n_d = 1'b1;
        if (state_q == ST_ON && !suppress) begin
            seg_d  = hex7(nibble);
            dp_n_d = ~sh_dp_q[digit_q];
            if (pwm_q <= sh_bright_q) begin
                an_d = ~(4'b0001 << digit_q);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_BLANK;
            digit_q     <= 2'd0;
            guard_q     <= '0;
            pwm_q       <= 3'd0;
            segclk_q    <= 1'b1;
            sh_value_q  <= 16'h0000;
            sh_dp_q     <= 4'h0;
            sh_bright_q <= 3'd0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_n_q      <= 1'b1;
        end else begin
            segclk_q <= segclk;
            pwm_q    <= pwm_q + 3'd1;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_n_q   <= dp_n_d;
            if (tick) begin
                digit_q <= digit_q + 2'd1;
                state_q <= ST_BLANK;
                guard_q <= '0;
                // Frame boundary: inputs become visible only from the next digit 0.
                if (digit_q == 2'd3) begin
                    sh_value_q  <= value;
                    sh_dp_q     <= dp;
                    sh_bright_q <= bright;
                end
            end else if (state_q == ST_BLANK) begin
                guard_q <= guard_q + GW'(1);
                if (guard_done) begin
                    state_q <= ST_ON;
                end
            end
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;

endmodule
